// File: rtl/sd_mem_bridge.sv
// Splits 32-bit DMA word requests into two 16-bit memory transactions (high half first).
// Optional per-phase watchdog enabled by defining SD_MEM_BRIDGE_TIMEOUT_EN.
module sd_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_write,
    output logic        o_busy,
    output logic        o_ack,
    input  logic [3:0]  i_bank,
    input  logic [23:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_mem_request,
    output logic        o_mem_write,
    input  logic        i_mem_busy,
    input  logic        i_mem_ack,
    output logic [3:0]  o_mem_bank,
    output logic [24:0] o_mem_address,
    output logic [15:0] o_mem_data,
    input  logic [15:0] i_mem_data,
    output logic        o_timeout,
    output logic [2:0]  o_dbg_state
);
    // Handshake: upstream word is accepted on a rising edge where i_request = 1 and
    // o_busy = 0 in IDLE; a halfword is taken by memory on an edge with
    // o_mem_request = 1 and i_mem_busy = 0; i_mem_ack completes it one or more cycles later.
    typedef enum logic [2:0] {IDLE, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] data;
    logic        expired;

    assign o_dbg_state = state;

`ifdef SD_MEM_BRIDGE_TIMEOUT_EN
    logic [7:0] cnt;

    assign expired = (state != IDLE) && (state != DONE) && (cnt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt       <= 8'd0;
            o_timeout <= 1'b0;
        end else if (state == IDLE && i_request) begin
            cnt       <= 8'd0;
            o_timeout <= 1'b0;
        end else if (expired) begin
            cnt       <= 8'd0;
            o_timeout <= 1'b1;
        end else if (state == HI_WAIT && i_mem_ack) begin
            cnt <= 8'd0;
        end else if (state != IDLE && state != DONE) begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    logic [7:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
    assign expired            = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            data          <= 32'h0;
            o_busy        <= 1'b0;
            o_ack         <= 1'b0;
            o_data        <= 32'h0;
            o_mem_request <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_bank    <= 4'h0;
            o_mem_address <= 25'h0;
            o_mem_data    <= 16'h0;
        end else begin
            o_ack <= 1'b0;
            if (expired) begin
                // Watchdog abort: finish the word with an all-ones result.
                state         <= DONE;
                o_ack         <= 1'b1;
                o_busy        <= 1'b0;
                o_data        <= 32'hFFFF_FFFF;
                o_mem_request <= 1'b0;
                o_mem_write   <= 1'b0;
                o_mem_bank    <= 4'h0;
                o_mem_address <= 25'h0;
                o_mem_data    <= 16'h0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_request) begin
                            state         <= HI_REQ;
                            data          <= i_data;
                            o_busy        <= 1'b1;
                            o_mem_request <= 1'b1;
                            o_mem_write   <= i_write;
                            o_mem_bank    <= i_bank;
                            o_mem_address <= {i_address, 1'b0};
                            o_mem_data    <= i_data[31:16];
                        end
                    end
                    HI_REQ: begin
                        if (!i_mem_busy) begin
                            state         <= HI_WAIT;
                            o_mem_request <= 1'b0;
                        end
                    end
                    HI_WAIT: begin
                        if (i_mem_ack) begin
                            state            <= LO_REQ;
                            o_mem_request    <= 1'b1;
                            o_mem_address[0] <= 1'b1;
                            o_mem_data       <= data[15:0];
                            if (!o_mem_write) data[31:16] <= i_mem_data;
                        end
                    end
                    LO_REQ: begin
                        if (!i_mem_busy) begin
                            state         <= LO_WAIT;
                            o_mem_request <= 1'b0;
                        end
                    end
                    LO_WAIT: begin
                        if (i_mem_ack) begin
                            state         <= DONE;
                            o_ack         <= 1'b1;
                            o_busy        <= 1'b0;
                            o_data        <= o_mem_write ? 32'h0 : {data[31:16], i_mem_data};
                            o_mem_write   <= 1'b0;
                            o_mem_bank    <= 4'h0;
                            o_mem_address <= 25'h0;
                            o_mem_data    <= 16'h0;
                        end
                    end
                    DONE: begin
                        // Requests seen here wait for the following IDLE cycle.
                        state  <= IDLE;
                        o_data <= 32'h0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/sd_mem_bridge.md
# sd_mem_bridge

Bridges the 32-bit DMA master port of the SD interface to the cartridge's 16-bit memory bus. Each accepted 32-bit word request is split into two halfword transactions, high halfword first. Read halfwords are reassembled into one 32-bit word, then returned with a single acknowledge. The block sits directly downstream of the SD interface DMA port and upstream of the memory arbiter.

## Interface
- TIMEOUT_CYCLES, 255, per-phase watchdog limit in clock cycles (1..255); used only with the timeout feature.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_request  in  1  upstream word request
- i_write  in  1  1 = write, 0 = read
- o_busy  out  1  bridge cannot accept a request
- o_ack  out  1  one-cycle completion pulse
- i_bank  in  4  target bank
- i_address  in  24  32-bit word address
- i_data  in  32  write data
- o_data  out  32  read data, valid while o_ack = 1
- o_mem_request  out  1  halfword request
- o_mem_write  out  1  halfword direction
- i_mem_busy  in  1  downstream cannot accept
- i_mem_ack  in  1  halfword completion
- o_mem_bank  out  4  target bank
- o_mem_address  out  25  halfword address
- o_mem_data  out  16  halfword write data
- i_mem_data  in  16  halfword read data, valid with i_mem_ack
- o_timeout  out  1  sticky flag: last transfer aborted

## Operation
- States: IDLE, HI_REQ, HI_WAIT, LO_REQ, LO_WAIT, DONE.
- IDLE
  - Request accepted when i_request = 1 and o_busy = 0.
  - On accept, latch i_write, i_bank, i_address and i_data, clear o_timeout, then go to HI_REQ.
- HI_REQ
  - Drive o_mem_request = 1, o_mem_address = {addr, 1'b0}, o_mem_data = data[31:16].
  - Hold all of these until i_mem_busy = 0, then go to HI_WAIT.
- HI_WAIT
  - o_mem_request = 0.
  - On i_mem_ack: for reads, capture i_mem_data into data[31:16]; go to LO_REQ.
- LO_REQ / LO_WAIT
  - Same as the HI states, with address {addr, 1'b1} and data[15:0].
  - LO_WAIT goes to DONE on i_mem_ack.
- DONE
  - o_ack = 1 for one cycle; o_data = assembled word for reads, 32'h0 for writes.
  - o_busy = 0 in this cycle; return to IDLE.
- o_busy = 1 in all states except IDLE and DONE.
- A request presented during DONE is not accepted; it is accepted on the next IDLE cycle.
- o_mem_bank and o_mem_write equal the latched values throughout HI_REQ through LO_WAIT.
- i_mem_ack in IDLE, HI_REQ, LO_REQ or DONE is ignored.
- Address arithmetic: no carry into the bank. Word address 24'hFFFFFF maps to halfword addresses 25'h1FFFFFE and then 25'h1FFFFFF.
- Upstream holds i_request until it is accepted and drops it in the following cycle.

## Timing
- Reset (asynchronous, i_reset = 0): state = IDLE. All outputs 0, including o_data, o_timeout and o_mem_*.
- Reset asserted mid-transfer aborts immediately, with no o_ack.
- The state register is clocked on the rising edge of i_clk; outputs are registered or decoded only from state.
- Minimum latency, with i_mem_busy = 0 and i_mem_ack one cycle after each memory request:
  - accept at cycle 0;
  - high request at cycle 1, high ack at cycle 2;
  - low request at cycle 3, low ack at cycle 4;
  - o_ack at cycle 5.
- Each cycle with i_mem_busy = 1 adds one cycle; each cycle of ack delay adds one cycle.
- Minimum spacing between two back-to-back accepts is 6 cycles.

## Configuration
- SD_MEM_BRIDGE_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to HI_REQ and on entry to LO_REQ.
  - It increments every cycle in the *_REQ and *_WAIT states.
  - When it reaches TIMEOUT_CYCLES: drop o_mem_request, set o_timeout = 1, go to DONE.
  - The resulting o_ack carries o_data = 32'hFFFF_FFFF.
  - A late i_mem_ack arriving afterwards is ignored.
- SD_MEM_BRIDGE_TIMEOUT_EN undefined:
  - No counter; waits indefinitely.
  - o_timeout is tied to 0.

## Test plan
- Read, bank 1, address 24'h000010, downstream returns 16'hDEAD then 16'hBEEF:
  - mem addresses 25'h000020 then 25'h000021;
  - o_ack at cycle 5 with o_data = 32'hDEADBEEF.
- Write 32'h12345678 to address 24'h000004:
  - o_mem_data = 16'h1234 at address 25'h000008, then 16'h5678 at 25'h000009, both with o_mem_write = 1;
  - o_data = 0 during o_ack.
- i_mem_busy held 1 for 3 cycles in HI_REQ: o_mem_request and the address stay stable; o_ack arrives at cycle 8.
- Word address 24'hFFFFFF, bank 3: halfword addresses 25'h1FFFFFE and 25'h1FFFFFF; o_mem_bank = 3 throughout.
- i_reset pulsed low during HI_WAIT: all outputs 0 immediately, no o_ack; the next request completes normally.
- With the macro defined and TIMEOUT_CYCLES = 8, no i_mem_ack: o_ack at cycle 10 with o_data = 32'hFFFFFFFF and o_timeout = 1; o_timeout clears on the next accept.
